// File: rtl/seq_adder_64_ctrl.sv
// Purpose: 64-bit adder that time-shares one 32-bit adder slice, low half first and then high half.
// Latency: done pulses 3 cycles after the start is accepted; at most one accept every 4 cycles.
// Backpressure: start is sampled only in IDLE; a start while busy is dropped and the operation in flight is unaffected.

module full_adder_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    // Plain ripple add of one 32-bit slice; the carry out is the 33rd bit.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    end

endmodule

module seq_adder_64_ctrl #(
    parameter int HALF_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2*HALF_W-1:0] a,
    input  logic [2*HALF_W-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [2*HALF_W-1:0] sum,
    output logic                cout,
    output logic                ovf
);

    localparam int W = 2 * HALF_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic              cin_r;
    logic              c_r;

    logic [HALF_W-1:0] add_a;
    logic [HALF_W-1:0] add_b;
    logic              add_cin;
    logic [HALF_W-1:0] add_sum;
    logic              add_cout;

    // State register; reset returns to IDLE and drops any request on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE waits for start, then LO -> HI -> DONE -> IDLE unconditionally.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? LO : IDLE;
            LO:      state_nxt = HI;
            HI:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Shared slice input mux: low half with the caller's carry, high half with the latched carry.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            LO: begin
                add_a   = a_r[HALF_W-1:0];
                add_b   = b_r[HALF_W-1:0];
                add_cin = cin_r;
            end
            HI: begin
                add_a   = a_r[W-1:HALF_W];
                add_b   = b_r[W-1:HALF_W];
                add_cin = c_r;
            end
            default: begin
                add_a   = '0;
                add_b   = '0;
                add_cin = 1'b0;
            end
        endcase
    end

    full_adder_32_bit u_slice (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Datapath: capture operands on accept, write each result half as its slice completes, pulse done once.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            cin_r <= 1'b0;
            c_r   <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        cin_r <= cin;
                    end
                end
                LO: begin
                    sum[HALF_W-1:0] <= add_sum;
                    c_r             <= add_cout;
                end
                HI: begin
                    sum[W-1:HALF_W] <= add_sum;
                    cout            <= add_cout;
                    // Signed overflow: like-signed operands producing a result of the other sign.
                    ovf             <= (a_r[W-1] == b_r[W-1]) && (add_sum[HALF_W-1] != a_r[W-1]);
                    done            <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule
